// File: rtl/inc_dec_driver_if.sv
// Step bus between the inc/dec driver (master) and the 8-bit inc/dec counter (slave).
// cnt_set is the step strobe; the counter acts on its rising edge.
// cnt_reset qualifies a step as a clear; cnt_ctrl selects direction (0 = up, 1 = down).
interface inc_dec_driver_if;
    logic cnt_set;
    logic cnt_reset;
    logic cnt_ctrl;

    modport master (
        output cnt_set,
        output cnt_reset,
        output cnt_ctrl
    );

    modport slave (
        input cnt_set,
        input cnt_reset,
        input cnt_ctrl
    );
endinterface

// File: rtl/inc_dec_driver.sv
// Initiator for the inc/dec counter step bus. Accepts a target or a clear command in IDLE,
// then emits timed cnt_set pulses until its shadow copy of the counter reaches the target.
// Optional feature: define INC_DEC_DRIVER_SHORTEST_EN to take the shorter modular path
// (wrap-around through 0 allowed, ties increment). Without it the direction is a plain
// unsigned compare and the counter never wraps.
// Reset is synchronous and does not reach the counter; issue clr afterwards to resync.
module inc_dec_driver #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PULSE_HIGH = 2,
    parameter int unsigned PULSE_LOW  = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic                 clr_i,
    input  logic [WIDTH-1:0]     target_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WIDTH-1:0]     shadow_o,
    inc_dec_driver_if.master     step_if
);

    localparam int unsigned MaxPulse = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
    localparam int unsigned CntW     = (MaxPulse > 1) ? $clog2(MaxPulse) : 1;
    localparam logic [CntW-1:0] HighLoad = CntW'(PULSE_HIGH - 1);
    localparam logic [CntW-1:0] LowLoad  = CntW'(PULSE_LOW - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StDone
    } state_e;

    state_e            state_q;
    logic              clear_q;      // 1: current operation is a clear, 0: a move
    logic [WIDTH-1:0]  target_q;
    logic [WIDTH-1:0]  shadow_q;
    logic [CntW-1:0]   pulse_cnt_q;
    logic              cnt_set_q;
    logic              cnt_reset_q;
    logic              cnt_ctrl_q;
    logic              busy_q;
    logic              done_q;

    logic              dir_dec;      // direction for a new move, 1 = decrement
    logic [WIDTH-1:0]  shadow_step;  // shadow value after the step about to be issued

`ifdef INC_DEC_DRIVER_SHORTEST_EN
    localparam logic [WIDTH-1:0] Half = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] fwd_dist;

    // Shorter modular path; a distance of exactly half goes up.
    always_comb begin
        fwd_dist = target_i - shadow_q;
        dir_dec  = (fwd_dist > Half);
    end
`else
    // Plain unsigned compare; the move never crosses 0/max.
    always_comb begin
        dir_dec = (target_i < shadow_q);
    end
`endif

    // Shadow tracks what the counter will hold after the strobe edge being raised.
    always_comb begin
        if (clear_q) begin
            shadow_step = '0;
        end else if (cnt_ctrl_q) begin
            shadow_step = shadow_q - 1'b1;
        end else begin
            shadow_step = shadow_q + 1'b1;
        end
    end

    // Operation sequencer with registered step-bus and status outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            clear_q     <= 1'b0;
            target_q    <= '0;
            shadow_q    <= '0;
            pulse_cnt_q <= '0;
            cnt_set_q   <= 1'b0;
            cnt_reset_q <= 1'b0;
            cnt_ctrl_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clr_i) begin
                        clear_q     <= 1'b1;
                        cnt_reset_q <= 1'b1;
                        cnt_ctrl_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StSetup;
                    end else if (start_i) begin
                        target_q <= target_i;
                        busy_q   <= 1'b1;
                        if (target_i == shadow_q) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            clear_q    <= 1'b0;
                            cnt_ctrl_q <= dir_dec;
                            state_q    <= StSetup;
                        end
                    end
                end
                // One cycle of stable ctrl/reset before the first strobe edge.
                StSetup: begin
                    cnt_set_q   <= 1'b1;
                    shadow_q    <= shadow_step;
                    pulse_cnt_q <= HighLoad;
                    state_q     <= StHigh;
                end
                StHigh: begin
                    if (pulse_cnt_q == '0) begin
                        cnt_set_q   <= 1'b0;
                        pulse_cnt_q <= LowLoad;
                        state_q     <= StLow;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - 1'b1;
                    end
                end
                StLow: begin
                    if (pulse_cnt_q == '0) begin
                        if (clear_q || (shadow_q == target_q)) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            cnt_set_q   <= 1'b1;
                            shadow_q    <= shadow_step;
                            pulse_cnt_q <= HighLoad;
                            state_q     <= StHigh;
                        end
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cnt_reset_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign step_if.cnt_set   = cnt_set_q;
    assign step_if.cnt_reset = cnt_reset_q;
    assign step_if.cnt_ctrl  = cnt_ctrl_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign shadow_o          = shadow_q;

endmodule

// File: doc/inc_dec_driver.md
Name: inc_dec_driver

Overview:
- Initiator for the 8-bit inc/dec counter's step interface. The counter is the responder.
- Accepts a target value or a clear command, then generates properly timed set/reset/ctrl pulses until the counter reaches the target.
- Keeps a shadow copy of the counter value.
- Sits between control logic and the counter; the counter's own ports connect directly to cnt_set/cnt_reset/cnt_ctrl.

Parameters:
- WIDTH, 8, counter and target width.
- PULSE_HIGH, 2, clk cycles cnt_set held high per step (>=1).
- PULSE_LOW, 2, clk cycles cnt_set held low after each step (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request move to target; sampled in IDLE only.
- clr  input  1  request counter clear; sampled in IDLE only; priority over start.
- target  input  WIDTH  destination value, captured when start accepted.
- cnt_set  output  1  step strobe to counter (counter acts on its rising edge).
- cnt_reset  output  1  clear qualifier to counter.
- cnt_ctrl  output  1  direction to counter: 0 = increment, 1 = decrement.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse at operation end.
- shadow  output  WIDTH  driver's copy of the counter value.

Behaviour:
- Reset (reset=0 at clk edge): state IDLE; cnt_set=0, cnt_reset=0, cnt_ctrl=0, busy=0, done=0, shadow=0, captured target=0.
  - Reset does not reach the counter. The system must issue clr after reset to resynchronise. This also applies to a reset taken mid-operation: it is an immediate abort, cnt_set drops low in the next cycle, and no further pulses are issued.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE:
  - clr=1: cnt_reset:=1, cnt_ctrl:=0, go to SETUP with mode CLEAR.
  - Else start=1: capture target.
    - target==shadow: go straight to DONE; no pulses.
    - Otherwise cnt_ctrl:=(target<shadow), unsigned compare; go to SETUP with mode MOVE.
- SETUP: one cycle; cnt_ctrl/cnt_reset stable with cnt_set=0. This guarantees >=1 cycle setup before the strobe edge. Then go to HIGH.
- HIGH:
  - cnt_set=1 for PULSE_HIGH cycles.
  - On entry, shadow updates in the same edge that raises cnt_set: CLEAR gives 0; MOVE gives shadow+1 if ctrl=0, else shadow-1, mod 2^WIDTH.
  - cnt_ctrl and cnt_reset are held through HIGH. Then go to LOW.
- LOW: cnt_set=0 for PULSE_LOW cycles. Then:
  - CLEAR, or MOVE with shadow==captured target: go to DONE.
  - Otherwise go to HIGH (direction unchanged for the whole operation).
- DONE: done=1 for exactly one cycle; cnt_reset:=0, busy:=0 on exit; return to IDLE.
- busy=1 in SETUP, HIGH, LOW and DONE; 0 in IDLE.
- start/clr outside IDLE are ignored, not queued. target changes after capture have no effect.
- Timing for a MOVE of N steps, with start accepted at edge E0:
  - busy=1 from E0.
  - First cnt_set rise at E0+2.
  - done high during cycle E0+1+N*(PULSE_HIGH+PULSE_LOW)+1.
  - Zero-step MOVE: done in the cycle after E0.
- Maximum move in base build is 2^WIDTH-1 steps (e.g. 0->255 increments 255 times). No wrap-around is used in the base build.

Optional Feature:
- Macro INC_DEC_DRIVER_SHORTEST_EN.
- Defined: direction selects the shorter modular path. d=(target-shadow) mod 2^WIDTH; increment if d<=2^(WIDTH-1), else decrement. Wrap-around through 0/255 is allowed; on a tie, increment.
  - Example: shadow=250, target=3 gives 9 increments, wrapping 255->0.
- Not defined: plain unsigned compare as in Behaviour. 250->3 gives 247 decrements.

Test Plan:
- reset=0 for 2 cycles, then clr: all outputs 0 during reset. After clr: one cnt_set pulse with cnt_reset=1 and cnt_ctrl=0 from SETUP through LOW; shadow=0; done after 6 cycles (defaults).
- shadow=0, start with target=3 (defaults): 3 cnt_set pulses, each 2 high/2 low; cnt_ctrl=0 throughout; shadow steps 1,2,3 on rising strobes; done at E0+14; attached counter reads 3.
- shadow=3, target=1: cnt_ctrl=1 one cycle before first strobe; 2 pulses; shadow=1; counter reads 1.
- target==shadow=5 with start: no cnt_set activity; done in cycle E0+1; busy high only that cycle.
- Start 0->10; after the 2nd strobe, pulse start (target=0) and clr: both ignored, 10 pulses complete. Then reset=0 mid-move on a repeat: outputs 0 next cycle and no further strobes.
- With INC_DEC_DRIVER_SHORTEST_EN: 250->3 gives 9 increments, shadow 255->0 wrap; without it, 247 decrements. Tie 0->128 gives 128 increments.
